shift_win_ctrl: RTL and testbench
=================================

// Module: shift_win_ctrl
// PURPOSE
//  Sequencer for the 4-tap ShiftReg4 window register in the CNN datapath. It accepts a raster pixel
//  stream (row_len x num_rows) and drives the shift register's en/pause pins so one sample shifts
//  per accepted beat. It flags when the taps hold a complete, same-row KSIZE-wide window, tags the
//  window with row/col indices, and applies downstream backpressure by freezing the shift register.
// PARAMETERS
//  KSIZE  4   window width; must equal the tap count of the driven shift register
//  COL_W  10  width of row_len and column counters
//  ROW_W  10  width of num_rows and row counters
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous, active-low reset
//  start         in   1      1-cycle pulse; latches cfg_row_len/cfg_num_rows; honoured only in IDLE
//  abort         in   1      synchronous return to IDLE from any state
//  cfg_row_len   in   COL_W  samples per row
//  cfg_num_rows  in   ROW_W  rows per frame
//  in_valid      in   1      upstream sample valid (data goes straight to the shift register)
//  in_ready      out  1      sample accepted when in_valid & in_ready
//  sr_en         out  1      to shift register en
//  sr_pause      out  1      to shift register pause
//  win_valid     out  1      shift-register taps hold a valid window
//  win_ready     in   1      downstream consumes window when win_valid & win_ready
//  win_col       out  COL_W  column of newest tap (KSIZE-1 .. row_len-1)
//  win_row       out  ROW_W  row index of window
//  win_last      out  1      last window of frame (qualified by win_valid)
//  busy          out  1      state != IDLE
//  done          out  1      1-cycle pulse, frame complete
//  cfg_err       out  1      1-cycle pulse, start rejected
// BEHAVIOUR
//  Reset values: state=IDLE, counters=0, in_ready=0, win_valid=0, win_col=0, win_row=0,
//   win_last=0, busy=0, done=0, cfg_err=0, sr_en=1, sr_pause=1.
//  Shift control: sr_en is held at 1; sr_pause = ~(in_valid & in_ready), so a shift occurs only on an accepted beat.
//  in_ready = (state==FILL | state==RUN) & (~win_valid | win_ready).
//   Consequence: an unconsumed window freezes both input and taps.
//  States:
//   IDLE    -> on start: if cfg_row_len<KSIZE or cfg_num_rows==0, pulse cfg_err and stay IDLE;
//              else latch cfg, clear col/row, go FILL
//   FILL    -> accept beats (col++); on the beat with col==KSIZE-1, go RUN
//   RUN     -> every accepted beat produces a window; on the beat with col==row_len-1, go ROW_END
//   ROW_END -> 1 cycle, in_ready=0; col<=0, row++; then FILL, or DRAIN if row was num_rows-1
//   DRAIN   -> wait until ~win_valid | win_ready; then pulse done, go IDLE
//  Window timing: win_valid, win_col, win_row and win_last are registered on the same edge the
//   accepted sample enters tap0, so they align with the shift-register outputs (latency 1 from beat).
//   - Set on an accepted beat with col>=KSIZE-1; cleared on win_ready when no new window is loaded.
//   - Simultaneous consume + new window: win_valid stays 1 with updated tags.
//  Windows never straddle rows: the FILL refill discards the KSIZE-1 stale taps.
//   Windows per row = row_len-KSIZE+1; col wraps to 0 at each row end.
//  win_last = 1 for row==num_rows-1 and col==row_len-1.
//  abort: highest priority; next cycle state=IDLE and win_valid=0; no done pulse; tap contents are don't-care.
//  start outside IDLE is ignored. rst_n low mid-frame restores all reset values immediately.
//  Counter arithmetic is unsigned and never exceeds the latched config (no overflow).
// STRUCTURE
//  Shared package cnn_win_pkg: state encoding (IDLE, FILL, RUN, ROW_END, DRAIN), KSIZE default.
//  One sub-module, win_tc_counter: loadable up-counter with terminal-count flag,
//   instantiated for col and row.
//  FSM and output registers sit in this module; ShiftReg4 is instantiated by the parent, not here.
// TESTING
//  1 Reset mid-frame -> all outputs at reset values next cycle, sr_pause=1, in_ready=0.
//  2 row_len=6, num_rows=2, in_valid=1, win_ready=1:
//     -> 12 beats accepted; windows at col 3,4,5 per row (6 total);
//     -> win_last on row1/col5; done 2 cycles after the last beat.
//  3 First window held by win_ready=0 for 5 cycles:
//     -> in_ready=0 and sr_pause=1 for those 5 cycles; win_col stays 3; resumes at col 4.
//  4 start with cfg_row_len=3 (or cfg_num_rows=0):
//     -> cfg_err pulse, busy=0, in_ready stays 0.
//  5 abort during RUN at col 4:
//     -> IDLE next cycle, win_valid=0, no done; a new start runs cleanly.
//  6 in_valid toggled 1,0,0,1 during FILL:
//     -> sr_pause=1 in the gaps; first window still appears only after the 4th accepted beat.

Source files
------------

// File: rtl/cnn_win_pkg.sv
// Shared definitions for the CNN window sequencer: FSM state encoding and default kernel width.
package cnn_win_pkg;

  localparam int unsigned KSIZE_DEF = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FILL    = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_ROW_END = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

endpackage

// File: rtl/win_tc_counter.sv
// Loadable up-counter with a combinational terminal-count flag against a runtime limit.
module win_tc_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         at_term_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o     = cnt_q;
  assign at_term_c = (cnt_q == term_i);

endmodule

// File: rtl/shift_win_ctrl.sv
// Sequencer for the ShiftReg4 window register: paces the raster stream into the taps and
// tags each complete same-row window with its row/column, stalling on downstream backpressure.
module shift_win_ctrl
  import cnn_win_pkg::*;
#(
  parameter int unsigned KSIZE = KSIZE_DEF,
  parameter int unsigned COL_W = 10,
  parameter int unsigned ROW_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [COL_W-1:0] cfg_row_len,
  input  logic [ROW_W-1:0] cfg_num_rows,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sr_en,
  output logic             sr_pause,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic             win_last,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [COL_W-1:0] K_LAST = COL_W'(KSIZE - 1);

  logic [2:0]       state_q, state_d;
  logic [COL_W-1:0] row_len_q, row_len_d;
  logic [ROW_W-1:0] num_rows_q, num_rows_d;
  logic             win_valid_q, win_valid_d;
  logic [COL_W-1:0] win_col_q, win_col_d;
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic             win_last_q, win_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             col_clr, col_inc, row_clr, row_inc;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             col_tc, row_tc;
  logic             accept, cfg_bad;

  win_tc_counter #(.W(COL_W)) u_col (
    .clk(clk), .rst_n(rst_n), .clr_i(col_clr), .inc_i(col_inc),
    .term_i(row_len_q - COL_W'(1)), .cnt_o(col_cnt), .at_term_c(col_tc)
  );

  win_tc_counter #(.W(ROW_W)) u_row (
    .clk(clk), .rst_n(rst_n), .clr_i(row_clr), .inc_i(row_inc),
    .term_i(num_rows_q - ROW_W'(1)), .cnt_o(row_cnt), .at_term_c(row_tc)
  );

  // A pending unconsumed window stalls both the input and the taps.
  assign in_ready = ((state_q == S_FILL) || (state_q == S_RUN)) && (!win_valid_q || win_ready);
  assign accept   = in_valid && in_ready;
  assign sr_en    = 1'b1;
  assign sr_pause = !accept;
  assign cfg_bad  = (cfg_row_len < COL_W'(KSIZE)) || (cfg_num_rows == '0);

  always_comb begin
    state_d     = state_q;
    row_len_d   = row_len_q;
    num_rows_d  = num_rows_q;
    win_valid_d = win_valid_q;
    win_col_d   = win_col_q;
    win_row_d   = win_row_q;
    win_last_d  = win_last_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    col_clr     = 1'b0;
    col_inc     = 1'b0;
    row_clr     = 1'b0;
    row_inc     = 1'b0;

    if (abort) begin
      state_d     = S_IDLE;
      win_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err_d = 1'b1;
            end else begin
              row_len_d  = cfg_row_len;
              num_rows_d = cfg_num_rows;
              col_clr    = 1'b1;
              row_clr    = 1'b1;
              state_d    = S_FILL;
            end
          end
        end
        // A row exactly KSIZE wide ends on its first window, straight from FILL.
        S_FILL: begin
          if (accept) begin
            if (col_tc) begin
              state_d = S_ROW_END;
            end else begin
              col_inc = 1'b1;
              if (col_cnt == K_LAST) state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            if (col_tc) state_d = S_ROW_END;
            else        col_inc = 1'b1;
          end
        end
        S_ROW_END: begin
          col_clr = 1'b1;
          if (row_tc) begin
            state_d = S_DRAIN;
          end else begin
            row_inc = 1'b1;
            state_d = S_FILL;
          end
        end
        S_DRAIN: begin
          if (!win_valid_q || win_ready) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Window tags are loaded on the edge that shifts the sample into tap0.
      if (accept && (col_cnt >= K_LAST)) begin
        win_valid_d = 1'b1;
        win_col_d   = col_cnt;
        win_row_d   = row_cnt;
        win_last_d  = row_tc && col_tc;
      end else if (win_ready) begin
        win_valid_d = 1'b0;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      row_len_q   <= '0;
      num_rows_q  <= '0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
      win_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_len_q   <= row_len_d;
      num_rows_q  <= num_rows_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
      win_row_q   <= win_row_d;
      win_last_q  <= win_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_col   = win_col_q;
  assign win_row   = win_row_q;
  assign win_last  = win_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_shift_win_ctrl.sv
// Directed self-checking bench for shift_win_ctrl; outputs sampled on the falling edge.
module tb_shift_win_ctrl;

  localparam int unsigned COL_W = 10;
  localparam int unsigned ROW_W = 10;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, in_valid, win_ready;
  logic [COL_W-1:0] cfg_row_len;
  logic [ROW_W-1:0] cfg_num_rows;
  logic             in_ready, sr_en, sr_pause, win_valid, win_last, busy, done, cfg_err;
  logic [COL_W-1:0] win_col;
  logic [ROW_W-1:0] win_row;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_win_ctrl #(.KSIZE(4), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows),
    .in_valid(in_valid), .in_ready(in_ready), .sr_en(sr_en), .sr_pause(sr_pause),
    .win_valid(win_valid), .win_ready(win_ready), .win_col(win_col), .win_row(win_row),
    .win_last(win_last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  task automatic do_start(input int rl, input int nr);
    @(negedge clk);
    cfg_row_len  = COL_W'(rl);
    cfg_num_rows = ROW_W'(nr);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b1; win_ready = 1'b0;
    cfg_row_len = '0; cfg_num_rows = '0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if ({busy, done, cfg_err, win_valid, win_last, in_ready, sr_en, sr_pause} !== 8'b0000_0011) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 00000011", {busy, done, cfg_err, win_valid, win_last, in_ready, sr_en, sr_pause});
    end
    n_tests++;
    if (win_col !== '0 || win_row !== '0) begin
      n_fail++;
      $display("FAIL reset_tags got col=%0d row=%0d exp 0/0", win_col, win_row);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_frame;
    int beats = 0, nwin = 0, dones = 0, last_beat = -1, done_at = -1;
    do_start(6, 2);
    in_valid = 1'b1; win_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (win_valid) begin
        n_tests++;
        if ({win_row, win_col, win_last} !== {ROW_W'(nwin / 3), COL_W'(3 + nwin % 3), (nwin == 5)}) begin
          n_fail++;
          $display("FAIL frame_win%0d got row=%0d col=%0d last=%b exp row=%0d col=%0d last=%b",
                   nwin, win_row, win_col, win_last, nwin / 3, 3 + nwin % 3, nwin == 5);
        end
        nwin++;
      end
      if (done) begin dones++; done_at = c; end
      if (in_valid && in_ready) begin beats++; last_beat = c; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_tests++;
    if (beats !== 12) begin n_fail++; $display("FAIL frame_beats got %0d exp 12", beats); end
    n_tests++;
    if (nwin !== 6) begin n_fail++; $display("FAIL frame_windows got %0d exp 6", nwin); end
    n_tests++;
    if (dones !== 1) begin n_fail++; $display("FAIL frame_done_count got %0d exp 1", dones); end
    n_tests++;
    if (done_at - last_beat !== 3) begin
      n_fail++;
      $display("FAIL frame_done_latency got %0d exp 3 (sample offsets)", done_at - last_beat);
    end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_backpressure;
    int k = 0;
    do_start(6, 1);
    in_valid = 1'b1; win_ready = 1'b0;
    #1;
    while (!win_valid && k < 20) begin @(negedge clk); #1; k++; end
    n_tests++;
    if (win_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_window timeout got %b exp 1", win_valid); end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({in_ready, sr_pause, win_valid, win_col} !== {1'b0, 1'b1, 1'b1, COL_W'(3)}) begin
        n_fail++;
        $display("FAIL bp_hold%0d got rdy=%b pause=%b wv=%b col=%0d exp 0 1 1 3", i, in_ready, sr_pause, win_valid, win_col);
      end
      @(negedge clk); #1;
    end
    win_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    @(negedge clk); #1;
    n_tests++;
    if (win_valid !== 1'b1 || win_col !== COL_W'(4)) begin
      n_fail++;
      $display("FAIL bp_resume got wv=%b col=%0d exp 1 4", win_valid, win_col);
    end
    k = 0;
    while (!done && k < 20) begin @(negedge clk); #1; k++; end
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done timeout got %b exp 1", done); end
    in_valid = 1'b0;
  endtask

  task automatic test_cfg_err;
    int rls[2] = '{3, 6};
    int nrs[2] = '{2, 0};
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      do_start(rls[i], nrs[i]);
      #1;
      n_tests++;
      if ({cfg_err, busy, in_ready} !== 3'b100) begin
        n_fail++;
        $display("FAIL cfg_err%0d got err=%b busy=%b rdy=%b exp 1 0 0", i, cfg_err, busy, in_ready);
      end
      @(negedge clk); #1;
      n_tests++;
      if ({cfg_err, busy, in_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL cfg_err_pulse%0d got err=%b busy=%b rdy=%b exp 0 0 0", i, cfg_err, busy, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_abort;
    int k = 0, dones = 0;
    do_start(6, 2);
    in_valid = 1'b1; win_ready = 1'b1;
    #1;
    while (!(win_valid && win_col == COL_W'(3)) && k < 20) begin @(negedge clk); #1; k++; end
    n_tests++;
    if (!(win_valid && win_col == COL_W'(3))) begin
      n_fail++; $display("FAIL abort_reach_col3 timeout got wv=%b col=%0d exp 1 3", win_valid, win_col);
    end
    abort = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b1;
    #1;
    n_tests++;
    if ({busy, win_valid, in_ready, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_idle got busy=%b wv=%b rdy=%b done=%b exp 0000", busy, win_valid, in_ready, done);
    end
    for (int i = 0; i < 5; i++) begin
      if (done) dones++;
      @(negedge clk); #1;
    end
    n_tests++;
    if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses exp 0", dones); end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    int nwin = 0, dones = 0, beats = 0;
    do_start(4, 1);
    in_valid = 1'b1; win_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (win_valid) begin
        nwin++;
        n_tests++;
        if ({win_row, win_col, win_last} !== {ROW_W'(0), COL_W'(3), 1'b1}) begin
          n_fail++;
          $display("FAIL b2b_window got row=%0d col=%0d last=%b exp 0 3 1", win_row, win_col, win_last);
        end
      end
      if (done) dones++;
      if (in_valid && in_ready) beats++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_tests++;
    if ({nwin, dones, beats} !== {32'd1, 32'd1, 32'd4}) begin
      n_fail++;
      $display("FAIL b2b_counts got win=%0d done=%0d beats=%0d exp 1 1 4", nwin, dones, beats);
    end
  endtask

  task automatic test_fill_gaps;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    do_start(6, 1);
    win_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i][0];
      #1;
      n_tests++;
      if ({sr_pause, win_valid} !== {~pat[i][0], 1'b0}) begin
        n_fail++;
        $display("FAIL fill_gap%0d got pause=%b wv=%b exp %b 0", i, sr_pause, win_valid, ~pat[i][0]);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (win_valid !== 1'b1 || win_col !== COL_W'(3)) begin
      n_fail++;
      $display("FAIL fill_first_window got wv=%b col=%0d exp 1 3", win_valid, win_col);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_start(6, 2);
    in_valid = 1'b1; win_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    n_tests++;
    if (win_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_active got wv=%b busy=%b exp 1 1", win_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, cfg_err, win_valid, win_last, in_ready, sr_en, sr_pause} !== 8'b0000_0011 ||
        win_col !== '0 || win_row !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got %b col=%0d row=%0d exp 00000011 0 0",
               {busy, done, cfg_err, win_valid, win_last, in_ready, sr_en, sr_pause}, win_col, win_row);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({busy, in_ready, sr_pause} !== 3'b001) begin
      n_fail++; $display("FAIL rstmid_after got busy=%b rdy=%b pause=%b exp 0 0 1", busy, in_ready, sr_pause);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_cfg_err();
    test_abort();
    test_back_to_back();
    test_fill_gaps();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
